// File: rtl/hazard_fwd_unit_if.sv
// D-stage operand/hazard bus between the pipeline and the hazard/forwarding unit.
interface hazard_fwd_unit_if #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int NPORT = 2
);
    logic [NPORT*AW-1:0] a_d;
    logic [NPORT*DW-1:0] rf_rd_d;
    logic [NPORT*2-1:0]  tuse_d;
    logic [AW-1:0]       a3_d;
    logic [1:0]          tnew_d;
    logic                md_start_d;
    logic                md_div_d;
    logic                md_use_d;
    logic [DW-1:0]       fwd_e;
    logic [DW-1:0]       fwd_m;
    logic [DW-1:0]       fwd_w;
    logic [NPORT*DW-1:0] opnd_d;
    logic                stall;
    logic                md_busy;

    modport master (
        output a_d, rf_rd_d, tuse_d, a3_d, tnew_d,
        output md_start_d, md_div_d, md_use_d,
        output fwd_e, fwd_m, fwd_w,
        input  opnd_d, stall, md_busy
    );

    modport slave (
        input  a_d, rf_rd_d, tuse_d, a3_d, tnew_d,
        input  md_start_d, md_div_d, md_use_d,
        input  fwd_e, fwd_m, fwd_w,
        output opnd_d, stall, md_busy
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// D-stage hazard unit: tracks in-flight writers with Tnew/Tuse, forwards
// operands, raises the D-stage stall and owns the mult/div busy counter.
module hazard_fwd_unit #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NPORT    = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input logic              clk,
    input logic              reset,
    hazard_fwd_unit_if.slave bus
);
    localparam int CW = $clog2(DIV_CYC + 1);

    logic [AW-1:0] e_a3, m_a3, w_a3;
    logic [1:0]    e_tnew, m_tnew, w_tnew;
    logic [CW-1:0] md_cnt;
    logic          data_stall;
    logic          md_stall;
    logic          stall_int;

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Per-port forwarding select and data-stall detection; youngest stage wins.
    always_comb begin
        logic [AW-1:0] a;
        logic [1:0]    tuse;
        logic          live;
        logic [DW-1:0] val;
        logic          need;
        data_stall = 1'b0;
        bus.opnd_d = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            a    = bus.a_d[i*AW +: AW];
            tuse = bus.tuse_d[i*2 +: 2];
            live = (a != '0) && (tuse != 2'd3);
            val  = bus.rf_rd_d[i*DW +: DW];
            need = 1'b0;
            if (live && a == e_a3) begin
                if (e_tnew == 2'd0) val = bus.fwd_e;
                need = (e_tnew > tuse);
            end else if (live && a == m_a3) begin
                if (m_tnew == 2'd0) val = bus.fwd_m;
                need = (m_tnew > tuse);
            end else if (live && a == w_a3) begin
                val  = bus.fwd_w;
                need = (w_tnew > tuse);
            end
            bus.opnd_d[i*DW +: DW] = val;
            data_stall = data_stall | need;
        end
    end

    assign md_stall    = (bus.md_start_d | bus.md_use_d) & bus.md_busy;
    assign stall_int   = data_stall | md_stall;
    assign bus.stall   = stall_int;
    assign bus.md_busy = (md_cnt != '0);

    // Shadow pipeline: E takes a bubble on stall, M and W always advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_a3   <= '0;
            e_tnew <= '0;
            m_a3   <= '0;
            m_tnew <= '0;
            w_a3   <= '0;
            w_tnew <= '0;
        end else begin
            if (stall_int) begin
                e_a3   <= '0;
                e_tnew <= '0;
            end else begin
                e_a3   <= bus.a3_d;
                e_tnew <= bus.tnew_d;
            end
            m_a3   <= e_a3;
            m_tnew <= sat_dec(e_tnew);
            w_a3   <= m_a3;
            w_tnew <= sat_dec(m_tnew);
        end
    end

    // Mult/div busy counter: loads on an accepted issue, otherwise counts down.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt <= '0;
        end else if (bus.md_start_d && !stall_int) begin
            md_cnt <= bus.md_div_d ? CW'(DIV_CYC) : CW'(MULT_CYC);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: cycle-by-cycle vector table plus hand-written
// multi-cycle sequences, with expectations queued and checked per cycle.
module tb_hazard_fwd_unit;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NP = 2;

    localparam logic [31:0] RF0  = 32'h1111_1111;
    localparam logic [31:0] RF1  = 32'h2222_2222;
    localparam logic [31:0] FWDE = 32'h0000_300C;
    localparam logic [31:0] FWDM = 32'h0000_0042;
    localparam logic [31:0] FWDW = 32'h0000_0077;

    localparam logic [1:0] S_RF = 2'd0;
    localparam logic [1:0] S_E  = 2'd1;
    localparam logic [1:0] S_M  = 2'd2;
    localparam logic [1:0] S_W  = 2'd3;

    typedef struct {
        logic [4:0] a0;
        logic [1:0] t0;
        logic [4:0] a1;
        logic [1:0] t1;
        logic [4:0] a3;
        logic [1:0] tn;
        logic       ms, mdv, mu;
        logic [1:0] s0, s1;
        logic       st, bz;
    } vec_t;

    typedef struct {
        logic [31:0] o0, o1;
        logic        st, bz;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t q[$];
    vec_t tbl[$];

    hazard_fwd_unit_if #(.DW(DW), .AW(AW), .NPORT(NP)) bus ();

    hazard_fwd_unit #(
        .DW(DW), .AW(AW), .NPORT(NP), .MULT_CYC(5), .DIV_CYC(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int a0, input int t0, input int a1, input int t1,
                                input int a3, input int tn, input int ms, input int mdv,
                                input int mu, input logic [1:0] s0, input logic [1:0] s1,
                                input int st, input int bz);
        vec_t v;
        v.a0 = 5'(a0); v.t0 = 2'(t0); v.a1 = 5'(a1); v.t1 = 2'(t1);
        v.a3 = 5'(a3); v.tn = 2'(tn);
        v.ms = 1'(ms); v.mdv = 1'(mdv); v.mu = 1'(mu);
        v.s0 = s0; v.s1 = s1; v.st = 1'(st); v.bz = 1'(bz);
        return v;
    endfunction

    function automatic logic [31:0] src_val(input logic [1:0] s, input logic [31:0] rf);
        case (s)
            S_E:     return FWDE;
            S_M:     return FWDM;
            S_W:     return FWDW;
            default: return rf;
        endcase
    endfunction

    task automatic expect_now(input logic [1:0] s0, input logic [1:0] s1,
                              input logic st, input logic bz);
        exp_t e;
        e.o0 = src_val(s0, RF0);
        e.o1 = src_val(s1, RF1);
        e.st = st;
        e.bz = bz;
        q.push_back(e);
    endtask

    // Drive one D-stage cycle at the falling edge and queue its expectation.
    task automatic apply(input vec_t v);
        @(negedge clk);
        bus.a_d        = {v.a1, v.a0};
        bus.tuse_d     = {v.t1, v.t0};
        bus.a3_d       = v.a3;
        bus.tnew_d     = v.tn;
        bus.md_start_d = v.ms;
        bus.md_div_d   = v.mdv;
        bus.md_use_d   = v.mu;
        expect_now(v.s0, v.s1, v.st, v.bz);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    task automatic check();
        exp_t e;
        #1;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard @%0t: got empty queue expected entry", $time);
        end else begin
            e = q.pop_front();
            cmp("opnd0", bus.opnd_d[31:0], e.o0);
            cmp("opnd1", bus.opnd_d[63:32], e.o1);
            cmp("stall", 32'(bus.stall), 32'(e.st));
            cmp("md_busy", 32'(bus.md_busy), 32'(e.bz));
        end
    endtask

    task automatic step(input vec_t v);
        apply(v);
        check();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.rf_rd_d = {RF1, RF0};
        bus.fwd_e   = FWDE;
        bus.fwd_m   = FWDM;
        bus.fwd_w   = FWDW;

        // Cycle-by-cycle sequence from an empty shadow pipeline.
        tbl.push_back(mk( 1,1,  2,1,  3,1, 0,0,0, S_RF,S_RF,0,0)); // addu $3
        tbl.push_back(mk( 3,0,  0,0,  0,0, 0,0,0, S_RF,S_RF,1,0)); // beq $3: stall
        tbl.push_back(mk( 3,0,  0,0,  0,0, 0,0,0, S_M ,S_RF,0,0)); // beq takes fwd_m
        tbl.push_back(mk(29,1,  0,3,  5,2, 0,0,0, S_RF,S_RF,0,0)); // lw $5
        tbl.push_back(mk( 5,1,  5,1,  6,1, 0,0,0, S_RF,S_RF,1,0)); // addu: load-use stall
        tbl.push_back(mk( 5,1,  5,1,  6,1, 0,0,0, S_RF,S_RF,0,0)); // proceeds, M.tnew=1
        tbl.push_back(mk( 6,3,  0,3,  0,0, 0,0,0, S_RF,S_RF,0,0)); // unused port ignores E hit
        tbl.push_back(mk( 0,3,  0,3,  7,2, 0,0,0, S_RF,S_RF,0,0)); // lw $7
        tbl.push_back(mk( 7,2,  6,0,  0,0, 0,0,0, S_RF,S_W ,0,0)); // sw data: no stall
        tbl.push_back(mk( 7,2,  0,3,  0,0, 0,0,0, S_RF,S_RF,0,0));
        tbl.push_back(mk( 7,0,  0,3,  0,0, 0,0,0, S_W ,S_RF,0,0));
        tbl.push_back(mk( 0,3,  0,3, 31,0, 0,0,0, S_RF,S_RF,0,0)); // jal
        tbl.push_back(mk(31,0,  0,3,  0,0, 0,0,0, S_E ,S_RF,0,0)); // jr $31
        tbl.push_back(mk( 0,3,  0,3,  4,0, 0,0,0, S_RF,S_RF,0,0));
        tbl.push_back(mk( 0,3,  0,3,  8,1, 0,0,0, S_RF,S_RF,0,0));
        tbl.push_back(mk( 0,3,  0,3,  4,0, 0,0,0, S_RF,S_RF,0,0));
        tbl.push_back(mk( 4,0,  8,1,  0,0, 0,0,0, S_E ,S_M ,0,0)); // E beats W for $4
        tbl.push_back(mk( 0,3,  0,3,  9,3, 0,0,0, S_RF,S_RF,0,0)); // tnew 3
        tbl.push_back(mk( 9,2,  0,3,  0,0, 0,0,0, S_RF,S_RF,1,0));
        tbl.push_back(mk( 9,2,  9,1,  0,0, 0,0,0, S_RF,S_RF,1,0));
        tbl.push_back(mk( 9,1,  9,0,  0,0, 0,0,0, S_W ,S_W ,1,0));
        tbl.push_back(mk( 9,0,  0,3,  0,0, 0,0,0, S_RF,S_RF,0,0));

        // Reset state: outputs pass rf_rd_d, no stall, not busy.
        apply(mk(3,0, 0,3, 0,0, 0,0,0, S_RF,S_RF,0,0));
        check();
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // div then mfhi: 10 busy cycles of stall, mfhi proceeds at count 0.
        step(mk(0,3, 0,3, 0,0, 1,1,0, S_RF,S_RF,0,0));
        for (int i = 0; i < 10; i++) step(mk(0,3, 0,3, 2,1, 0,0,1, S_RF,S_RF,1,1));
        step(mk(0,3, 0,3, 2,1, 0,0,1, S_RF,S_RF,0,0));

        // div, then mult while busy; first stalled cycle also has a data hazard.
        step(mk(0,3, 0,3, 11,2, 1,1,0, S_RF,S_RF,0,0));
        for (int i = 0; i < 10; i++) begin
            if (i == 0) step(mk(11,0, 0,3, 10,1, 1,0,0, S_RF,S_RF,1,1));
            else        step(mk( 0,3, 0,3, 10,1, 1,0,0, S_RF,S_RF,1,1));
        end
        // Every stalled cycle must have bubbled E, so $10 is not in flight.
        step(mk(10,0, 0,3, 0,0, 1,0,0, S_RF,S_RF,0,0));
        for (int i = 0; i < 5; i++) step(mk(0,3, 0,3, 0,0, 0,0,0, S_RF,S_RF,0,1));
        step(mk(0,3, 0,3, 0,0, 0,0,0, S_RF,S_RF,0,0));

        // Reset mid-divide at md_cnt = 7 with $12 in flight.
        step(mk(0,3, 0,3, 0,0, 1,1,0, S_RF,S_RF,0,0));
        for (int i = 0; i < 3; i++) step(mk(0,3, 0,3, 12,2, 0,0,0, S_RF,S_RF,0,1));
        apply(mk(12,0, 0,3, 0,0, 0,0,0, S_RF,S_RF,1,1));
        check();
        reset = 1'b0;
        expect_now(S_RF, S_RF, 1'b0, 1'b0);
        check();
        apply(mk(12,0, 0,3, 0,0, 0,0,0, S_RF,S_RF,0,0));
        check();
        apply(mk(12,0, 0,3, 0,0, 0,0,0, S_RF,S_RF,0,0));
        reset = 1'b1;
        check();
        step(mk(12,0, 0,3, 0,0, 0,0,0, S_RF,S_RF,0,0));

        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
